pyexec_host_bridge: RTL

- Sits directly downstream of thiele_cpu's PYEXEC port (py_req/py_code_addr/py_ack/py_result). It turns each CPU request into a host-side mailbox transaction and returns the host's 32-bit return code to the CPU as a single-cycle ack.
- Checks results in hardware, replacing testbench-side checks: non-digest calls must return rc=0; digest calls (code 0x5) must be non-zero and stable across the run.
- Adds a per-call timeout and exposes sticky failure status for the top level.

---
 rtl/thiele_pyexec_pkg.sv | 21 ++
 rtl/pyexec_result_checker.sv | 70 +++++++
 rtl/pyexec_host_bridge.sv | 110 +++++++++++
 3 files changed

// File: rtl/thiele_pyexec_pkg.sv
// Shared types and constants for the PYEXEC host bridge.
// State encoding, failure reason codes and default magic codes live here.
package thiele_pyexec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK  = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  localparam logic [2:0] FR_NONE            = 3'd0;
  localparam logic [2:0] FR_NONZERO_RC      = 3'd1;
  localparam logic [2:0] FR_ZERO_DIGEST     = 3'd2;
  localparam logic [2:0] FR_DIGEST_MISMATCH = 3'd3;
  localparam logic [2:0] FR_TIMEOUT         = 3'd4;

  localparam logic [31:0] DIGEST_CODE_DEFAULT = 32'h0000_0005;
  localparam logic [31:0] TIMEOUT_RC_DEFAULT  = 32'hFFFF_FFFF;

endpackage

// File: rtl/pyexec_result_checker.sv
// Judges each completed host call: captures the first digest and records
// the first failure seen (sticky until reset).
module pyexec_result_checker
  import thiele_pyexec_pkg::*;
#(
  parameter logic [31:0] DIGEST_CODE = DIGEST_CODE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_check,
  input  logic        i_timeout,
  input  logic [31:0] i_code,
  input  logic [31:0] i_rc,
  output logic        o_digest_valid,
  output logic [31:0] o_digest_value,
  output logic        o_fail,
  output logic [2:0]  o_fail_reason
);

  logic        r_digest_valid;
  logic [31:0] r_digest_value;
  logic        r_fail;
  logic [2:0]  r_fail_reason;
  logic        w_is_digest;
  logic        w_capture;
  logic [2:0]  w_reason;

  assign w_is_digest = (i_code == DIGEST_CODE);
  assign w_capture   = i_check && w_is_digest && (i_rc != 32'd0) && !r_digest_valid;

  always_comb begin
    w_reason = FR_NONE;
    if (i_timeout) begin
      w_reason = FR_TIMEOUT;
    end else if (i_check) begin
      if (!w_is_digest && (i_rc != 32'd0)) begin
        w_reason = FR_NONZERO_RC;
      end else if (w_is_digest && (i_rc == 32'd0)) begin
        w_reason = FR_ZERO_DIGEST;
      end else if (w_is_digest && r_digest_valid && (i_rc != r_digest_value)) begin
        w_reason = FR_DIGEST_MISMATCH;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digest_valid <= 1'b0;
      r_digest_value <= 32'd0;
      r_fail         <= 1'b0;
      r_fail_reason  <= FR_NONE;
    end else begin
      if (w_capture) begin
        r_digest_valid <= 1'b1;
        r_digest_value <= i_rc;
      end
      // Only the first failure is recorded; later ones leave the reason alone.
      if (!r_fail && (w_reason != FR_NONE)) begin
        r_fail        <= 1'b1;
        r_fail_reason <= w_reason;
      end
    end
  end

  assign o_digest_valid = r_digest_valid;
  assign o_digest_value = r_digest_value;
  assign o_fail         = r_fail;
  assign o_fail_reason  = r_fail_reason;

endmodule

// File: rtl/pyexec_host_bridge.sv
// Bridges CPU PYEXEC requests to a host mailbox with timeout, single-cycle
// ack back to the CPU and hardware result checking.
module pyexec_host_bridge
  import thiele_pyexec_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter logic [31:0] DIGEST_CODE    = DIGEST_CODE_DEFAULT,
  parameter logic [31:0] TIMEOUT_RC     = TIMEOUT_RC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        py_req,
  input  logic [31:0] py_code_addr,
  output logic        py_ack,
  output logic [31:0] py_result,
  output logic        host_req,
  output logic [31:0] host_code,
  input  logic        host_ack,
  input  logic [31:0] host_rc,
  output logic        busy,
  output logic        digest_valid,
  output logic [31:0] digest_value,
  output logic        fail,
  output logic [2:0]  fail_reason,
  output logic [15:0] call_count
);

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_timer;
  logic [31:0] r_host_code;
  logic [31:0] r_py_result;
  logic [15:0] r_call_count;
  logic        w_check;
  logic        w_timeout;

  always_comb begin
    w_state_next = r_state;
    w_check      = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: if (py_req) w_state_next = ST_REQ;
      ST_REQ: begin
        // A host ack arriving on the expiry cycle still counts as a real answer.
        if (host_ack) begin
          w_check      = 1'b1;
          w_state_next = ST_ACK;
        end else if (r_timer == TIMER_LAST) begin
          w_timeout    = 1'b1;
          w_state_next = ST_ACK;
        end
      end
      ST_ACK:  w_state_next = ST_GAP;
      ST_GAP:  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_timer      <= 16'd0;
      r_host_code  <= 32'd0;
      r_py_result  <= 32'd0;
      r_call_count <= 16'd0;
    end else begin
      r_state <= w_state_next;
      if ((r_state == ST_IDLE) && py_req) begin
        r_host_code <= py_code_addr;
        r_timer     <= 16'd0;
      end
      if ((r_state == ST_REQ) && !w_check && !w_timeout) begin
        r_timer <= r_timer + 16'd1;
      end
      if (w_check) begin
        r_py_result <= host_rc;
      end else if (w_timeout) begin
        r_py_result <= TIMEOUT_RC;
      end
      if ((r_state == ST_ACK) && (r_call_count != 16'hFFFF)) begin
        r_call_count <= r_call_count + 16'd1;
      end
    end
  end

  pyexec_result_checker #(
    .DIGEST_CODE(DIGEST_CODE)
  ) u_checker (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_check       (w_check),
    .i_timeout     (w_timeout),
    .i_code        (r_host_code),
    .i_rc          (host_rc),
    .o_digest_valid(digest_valid),
    .o_digest_value(digest_value),
    .o_fail        (fail),
    .o_fail_reason (fail_reason)
  );

  assign py_ack     = (r_state == ST_ACK);
  assign host_req   = (r_state == ST_REQ);
  assign busy       = (r_state != ST_IDLE);
  assign host_code  = r_host_code;
  assign py_result  = r_py_result;
  assign call_count = r_call_count;

endmodule
